// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, requester count, default timeout.
// Purely declarative; no logic, no latency, no flow control.
package uart_pkg;

    localparam int N_REQ       = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_RDY  = 2'd3
    } state_t;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search starting one past last_grant, ascending with wrap.
// Combinational, zero latency; no flow control.
module rr_pick
    import uart_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_grant,
    output logic             valid,
    output logic [1:0]       index
);

    logic [1:0] w_cand;

    // Walk from farthest to nearest so the nearest active requester overwrites.
    always_comb begin
        valid  = 1'b0;
        index  = last_grant;
        w_cand = last_grant;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = last_grant + 2'(i);
            if (req[w_cand]) begin
                valid = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates four byte requesters onto one tx_engine; grant/load pulse two edges after a request is seen.
// Holds requests off while txrdy is low; times out (sticky err) if txrdy never falls after a load.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [31:0]      data,
    output logic [N_REQ-1:0] gnt,
    input  logic             txrdy,
    output logic             load,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [1:0]       last_grant,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [7:0]       r_out;
    logic [N_REQ-1:0] r_gnt;
    logic             r_load;
    logic             r_busy;
    logic             r_err;
    logic [1:0]       r_lg;
    logic             w_pick_vld;
    logic [1:0]       w_pick_idx;
    logic             w_start;
    logic             w_timeout;

    rr_pick u_rr_pick (
        .req        (req),
        .last_grant (r_lg),
        .valid      (w_pick_vld),
        .index      (w_pick_idx)
    );

    assign w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (txrdy && w_pick_vld) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!txrdy) begin
                    w_state_nxt = ST_WAIT_RDY;
                end else if (w_cnt_nxt == TO) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (txrdy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_gnt   <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_lg    <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            // Strobes are registered from the LOAD state, so they appear the edge after it is entered.
            r_load  <= (r_state == ST_LOAD);
            r_gnt   <= (r_state == ST_LOAD) ? idx2onehot(r_lg) : '0;
            if (w_start) begin
                r_out <= data[{w_pick_idx, 3'b000} +: 8];
                r_lg  <= w_pick_idx;
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign gnt        = r_gnt;
    assign load       = r_load;
    assign out_data   = r_out;
    assign busy       = r_busy;
    assign last_grant = r_lg;
    assign err        = r_err;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles to wait for txrdy to fall after a load (1..255).
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req  in  4  per-requester transmit request, level, bit i = requester i.
REQ-005 Port: data  in  32  requester bytes; data[8i+7:8i] belongs to requester i.
REQ-006 Port: gnt  out  4  one-hot, one-cycle grant; byte of requester i accepted.
REQ-007 Port: txrdy  in  1  ready flag from tx_engine (1 = idle, may load).
REQ-008 Port: load  out  1  one-cycle load strobe to tx_engine.
REQ-009 Port: out_data  out  8  byte presented to tx_engine out_port.
REQ-010 Port: busy  out  1  high whenever the state is not IDLE.
REQ-011 Port: last_grant  out  2  index of the most recent winner.
REQ-012 Port: err  out  1  sticky timeout flag.
REQ-013 Port: err_clr  in  1  clears err when high for one cycle.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WAIT_BUSY, WAIT_RDY; all outputs SHALL be registered.
REQ-015 IDLE: when txrdy=1 and req!=0 at edge N, the block SHALL pick a winner, capture its byte into out_data and enter LOAD.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and ascends with wrap-around; last_grant updates to the winner.
REQ-017 LOAD (cycle N+1): load=1 and gnt[winner]=1 for exactly one cycle; next state WAIT_BUSY.
REQ-018 WAIT_BUSY: txrdy=0 SHALL move to WAIT_RDY; the timeout counter starts at 0 on entry and increments each cycle.
REQ-019 If the counter reaches TIMEOUT in WAIT_BUSY, err SHALL set to 1 and the FSM SHALL return to IDLE.
REQ-020 WAIT_RDY: txrdy=1 SHALL return to IDLE; no timeout applies in this state.
REQ-021 With txrdy=0 in IDLE, requests SHALL be held off; no grant is issued.
REQ-022 A requester deasserting req before its grant SHALL be dropped silently; changes on data after capture SHALL NOT affect out_data.
REQ-023 A requester may hold req high continuously and SHALL be granted at most once per full frame sequence (IDLE to IDLE).
REQ-024 If err_clr and a timeout occur in the same cycle, set SHALL win (err=1).
REQ-025 Timeout counter SHALL be 8 bits and saturate; TIMEOUT=0 is illegal.
REQ-026 Between consecutive grants, the minimum spacing SHALL be 4 cycles (LOAD, WAIT_BUSY, WAIT_RDY, IDLE).

Reset
REQ-027 Reset SHALL force IDLE, gnt=0, load=0, out_data=0, busy=0, err=0, counter=0 and last_grant=3 (requester 0 has first priority).
REQ-028 Reset asserted mid-frame SHALL abort immediately with no load or gnt pulse in the reset cycle or the cycle after it.

Structure
REQ-029 The state encoding, N_REQ=4 and the default TIMEOUT SHALL live in shared package uart_pkg.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs req and last_grant; outputs valid and index).

Verification
REQ-031 Single request: reset, then req=4'b0001, data[7:0]=8'hA5, txrdy=1. Expected: gnt=4'b0001, load=1 and out_data=8'hA5 exactly 2 edges after req; last_grant=0.
REQ-032 Round-robin: req=4'b1111 held; the model toggles txrdy low then high after each load. Expected: grant order 0,1,2,3,0.
REQ-033 Wrap and skip: last_grant=2 with req=4'b0011. Expected: grant to 0, then to 1; requester 2 is never granted.
REQ-034 Timeout: TIMEOUT=8 and txrdy held at 1 after a load. Expected: err=1 8 cycles after WAIT_BUSY entry, FSM back in IDLE, a new grant is possible, and err_clr returns err to 0.
REQ-035 Hold-off and withdrawal: txrdy=0 with req=4'b0100 for 10 cycles, then req=0 before txrdy rises. Expected: no gnt and no load.
REQ-036 Reset mid-frame: reset asserted in WAIT_BUSY. Expected: busy=0, load=0 and gnt=0 next cycle; last_grant=3.
